// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with integrated transmit FIFO
// Frame settings are captured at pop time so a frame in flight is immune to cfg changes.
module uart_tx_fifo #(
  parameter int MAX_W      = 9,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [MAX_W-1:0]              s_data,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [3:0]                    cfg_len,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0]    MAX_LEN = 4'(MAX_W);
  localparam logic [CW-1:0] FULL    = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  logic [MAX_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] baud_q, baud_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [MAX_W-1:0] shift_q, shift_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       len_q, len_d;
  logic             par_en_q, par_en_d;
  logic             par_bit_q, par_bit_d;
  logic             stop2_q, stop2_d;
  logic             stop_idx_q, stop_idx_d;
  logic             txd_q, txd_d;

  logic             bit_end;
  logic [MAX_W-1:0] head;
  logic [3:0]       eff_len;
  logic [MAX_W-1:0] load_data;
  logic             load_par_en;
  logic             load_par_bit;

  assign s_ready    = (count_q != FULL);
  assign push       = s_valid && s_ready;
  assign fifo_count = count_q;
  assign busy       = (state_q != S_IDLE) || (count_q != '0);
  assign txd        = txd_q;
  assign bit_end    = (baud_q == div_q);
  assign head       = mem_q[rd_ptr_q];

  // Storage needs no reset: entries are only ever read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // Out-of-range lengths fall back to the widest word; unused bits are zeroed
  // so neither the shifter nor the parity sees them.
  always_comb begin
    eff_len = ((cfg_len < 4'd5) || (cfg_len > MAX_LEN)) ? MAX_LEN : cfg_len;
    for (int i = 0; i < MAX_W; i++) begin
      load_data[i] = head[i] & (i < int'(eff_len));
    end
    load_par_en  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
    load_par_bit = (^load_data) ^ (cfg_parity == 2'b10);
  end

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    div_d      = div_q;
    len_d      = len_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    stop_idx_d = stop_idx_q;
    pop        = 1'b0;
    txd_d      = 1'b1;

    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + DIV_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == len_q - 4'd1) begin
            state_d    = par_en_q ? S_PARITY : S_STOP;
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d    = S_STOP;
          stop_idx_d = 1'b0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_idx_q == stop2_q) begin
            if (count_q != '0) begin
              pop = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A pop from IDLE or from the last stop bit starts the next frame directly.
    if (pop) begin
      state_d   = S_START;
      baud_d    = '0;
      shift_d   = load_data;
      div_d     = cfg_div;
      len_d     = eff_len;
      par_en_d  = load_par_en;
      par_bit_d = load_par_bit;
      stop2_d   = cfg_stop2;
    end

    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
      S_PARITY: txd_d = par_bit_d;
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      div_q      <= '0;
      len_q      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      div_q      <= div_d;
      len_q      <= len_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      stop_idx_q <= stop_idx_d;
      txd_q      <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed bench for uart_tx_fifo
// Single frames come from a hand-computed table; back-to-back, cfg latch and reset are hand sequences.
module tb_uart_tx_fifo;

  localparam int MAX_W = 9;
  localparam int DEPTH = 8;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             s_valid;
  logic             s_ready;
  logic [MAX_W-1:0] s_data;
  logic [DIV_W-1:0] cfg_div;
  logic [3:0]       cfg_len;
  logic [1:0]       cfg_parity;
  logic             cfg_stop2;
  logic             txd;
  logic             busy;
  logic [3:0]       fifo_count;

  always #5 clk = ~clk;

  uart_tx_fifo #(.MAX_W(MAX_W), .FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .cfg_div(cfg_div), .cfg_len(cfg_len), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .txd(txd), .busy(busy), .fifo_count(fifo_count)
  );

  typedef struct {
    logic [8:0]  data;
    logic [3:0]  len;
    logic [1:0]  par;
    logic        stop2;
    logic [15:0] div;
    logic [15:0] bits;   // bit i is the i-th line bit of the frame, start bit first
    int          nbits;
  } vec_t;

  vec_t tbl[6];
  int   n_vec  = 0;
  int   n_miss = 0;
  logic expq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_bit(input logic b, input int div);
    for (int c = 0; c <= div; c++) expq.push_back(b);
  endtask

  task automatic add_frame(input logic [8:0] d, input int len, input int par, input int stops, input int div);
    logic p;
    p = 1'b0;
    add_bit(1'b0, div);
    for (int i = 0; i < len; i++) begin
      add_bit(d[i], div);
      p = p ^ d[i];
    end
    if (par == 1) add_bit(p, div);
    if (par == 2) add_bit(~p, div);
    for (int s = 0; s < stops; s++) add_bit(1'b1, div);
  endtask

  initial begin
    logic [8:0] words[10];
    int         idx;
    logic       will_push;
    logic       saw_full;

    tbl[0] = '{9'h0A5, 4'd8, 2'b00, 1'b0, 16'd3, 16'h034A, 10};
    tbl[1] = '{9'h07F, 4'd7, 2'b01, 1'b1, 16'd0, 16'h07FE, 11};
    tbl[2] = '{9'h0FF, 4'd7, 2'b10, 1'b1, 16'd0, 16'h06FE, 11};
    tbl[3] = '{9'h100, 4'd9, 2'b10, 1'b0, 16'd1, 16'h0A00, 12};
    tbl[4] = '{9'h155, 4'd3, 2'b00, 1'b0, 16'd0, 16'h06AA, 11};
    tbl[5] = '{9'h1F3, 4'd5, 2'b11, 1'b0, 16'd2, 16'h0066, 7};

    reset = 1'b1; s_valid = 1'b0; s_data = '0;
    cfg_div = 16'd3; cfg_len = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd1);
    chk("rst_count", 32'(fifo_count), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      cfg_div = tbl[v].div; cfg_len = tbl[v].len; cfg_parity = tbl[v].par; cfg_stop2 = tbl[v].stop2;
      s_data = tbl[v].data; s_valid = 1'b1;
      chk($sformatf("v%0d_ready", v), 32'(s_ready), 32'd1);
      @(negedge clk);
      s_valid = 1'b0;
      chk($sformatf("v%0d_prepop_txd", v), 32'(txd), 32'd1);
      chk($sformatf("v%0d_prepop_count", v), 32'(fifo_count), 32'd1);
      for (int b = 0; b < tbl[v].nbits; b++) begin
        for (int c = 0; c <= int'(tbl[v].div); c++) begin
          @(negedge clk);
          chk($sformatf("v%0d_bit%0d", v, b), 32'(txd), 32'(tbl[v].bits[b]));
        end
      end
      @(negedge clk);
      chk($sformatf("v%0d_end_busy", v), 32'(busy), 32'd0);
      chk($sformatf("v%0d_end_txd", v), 32'(txd), 32'd1);
      @(negedge clk);
    end

    // Ten words pushed as fast as the FIFO allows at div=0: contiguous 10-cycle frames.
    words = '{9'h01, 9'h80, 9'h55, 9'hAA, 9'hFF, 9'h00, 9'h3C, 9'hC3, 9'h12, 9'hED};
    cfg_div = 16'd0; cfg_len = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    expq.delete();
    for (int w = 0; w < 10; w++) add_frame(words[w], 8, 0, 1, 0);
    idx = 0; saw_full = 1'b0;
    s_valid = 1'b1; s_data = words[0];
    for (int c = 1; c <= 102; c++) begin
      will_push = s_valid && s_ready;
      @(negedge clk);
      if (will_push) idx++;
      if (c >= 2 && c <= 101) chk($sformatf("b2b_txd_c%0d", c), 32'(txd), 32'(expq[c-2]));
      chk($sformatf("b2b_ready_c%0d", c), 32'(s_ready), 32'(fifo_count != 4'd8));
      if (fifo_count == 4'd8) saw_full = 1'b1;
      s_valid = (idx < 10);
      s_data  = (idx < 10) ? words[idx] : '0;
    end
    chk("b2b_accepted", 32'(idx), 32'd10);
    chk("b2b_saw_full", 32'(saw_full), 32'd1);
    chk("b2b_end_busy", 32'(busy), 32'd0);
    @(negedge clk);

    // Config changed mid-frame only takes effect on the following frame.
    cfg_div = 16'd2; cfg_len = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    expq.delete();
    add_frame(9'h096, 8, 0, 1, 2);
    add_frame(9'h069, 8, 0, 2, 5);
    s_data = 9'h096; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    for (int c = 2; c <= 97; c++) begin
      @(negedge clk);
      chk($sformatf("cfg_txd_c%0d", c), 32'(txd), 32'(expq[c-2]));
      if (c == 4) begin
        cfg_div = 16'd5; cfg_stop2 = 1'b1; s_data = 9'h069; s_valid = 1'b1;
      end else begin
        s_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("cfg_end_busy", 32'(busy), 32'd0);

    // Reset during a start bit with three words queued.
    cfg_div = 16'd3; cfg_len = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_data = 9'(i + 1); s_valid = 1'b1;
      @(negedge clk);
    end
    s_valid = 1'b0;
    chk("mid_count", 32'(fifo_count), 32'd3);
    chk("mid_txd_start", 32'(txd), 32'd0);
    reset = 1'b1;
    #1;
    chk("arst_txd", 32'(txd), 32'd1);
    chk("arst_count", 32'(fifo_count), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst_txd_c%0d", c), 32'(txd), 32'd1);
      chk($sformatf("post_rst_busy_c%0d", c), 32'(busy), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
